fp_normalize_pipe: RTL and testbench

Pipelined, parametrised normalisation and rounding stage for the floating-point adder datapath. Takes the raw mantissa sum (carry, hidden and fraction bits plus guard/round/sticky) and the pre-shift exponent. Finds the shift direction and amount itself using a leading-zero count, then applies it, rounds and saturates. Sits between the mantissa adder and result packing, with valid/ready flow control on both sides.

---
 rtl/fp_normalize_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalise/round/saturate stage for the FP adder, with valid/ready on both sides.
// Optional round-to-nearest-even via `ROUND_RNE_EN; truncation when undefined.
module fp_normalize_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic             clk73,
  input  logic             rst73,
  input  logic             in_valid73,
  output logic             in_ready73,
  input  logic             sign73,
  input  logic [EXP_W-1:0] exp73,
  input  logic [MAN_W+4:0] m_sum73,
  output logic             out_valid73,
  input  logic             out_ready73,
  output logic             res_sign73,
  output logic [EXP_W-1:0] res_exp73,
  output logic [MAN_W-1:0] res_mant73,
  output logic             zero73,
  output logic             ovf73,
  output logic             uf73
);

  localparam int W    = MAN_W + 5;
  localparam int LZ_W = $clog2(W);
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_RIGHT,
    CLS_LEFT
  } cls_e;

  logic ld1, ld2;

  logic             v1_q, v1_d;
  cls_e             cls1_q, cls1_d;
  logic             sign1_q, sign1_d;
  logic [EXP_W:0]   exp1_q, exp1_d;
  logic [LZ_W-1:0]  lz1_q, lz1_d;
  logic [W-3:0]     m1_q, m1_d;

  logic             v2_q, v2_d;
  logic             res_sign_q, res_sign_d;
  logic [EXP_W-1:0] res_exp_q, res_exp_d;
  logic [MAN_W-1:0] res_mant_q, res_mant_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             uf_q, uf_d;

  logic [LZ_W-1:0]  lz_c;
  logic             found;

  logic signed [EW-1:0] e_pre, e_fin;
  logic [MAN_W-1:0]     frac_r;
`ifdef ROUND_RNE_EN
  logic [W-3:0]         norm;
  logic [MAN_W-1:0]     frac;
  logic                 rnd_up;
  logic                 wrap;
`endif

  assign ld2        = !v2_q || out_ready73;
  assign ld1        = !v1_q || ld2;
  assign in_ready73 = ld1;

  // Leading zeros counted from the hidden-bit position downward.
  always_comb begin
    lz_c  = '0;
    found = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!found && m_sum73[i]) begin
        lz_c  = LZ_W'(W - 2 - i);
        found = 1'b1;
      end
    end
  end

  // The hidden bit is not stored: a left shift by lz pushes it out of the
  // register width, and a right shift replaces it with the carry.
  always_comb begin
    v1_d    = v1_q;
    cls1_d  = cls1_q;
    sign1_d = sign1_q;
    exp1_d  = exp1_q;
    lz1_d   = lz1_q;
    m1_d    = m1_q;
    if (ld1) begin
      v1_d = in_valid73;
      if (in_valid73) begin
        sign1_d = sign73;
        if (m_sum73 == '0) begin
          cls1_d = CLS_ZERO;
          exp1_d = '0;
          lz1_d  = '0;
          m1_d   = '0;
        end else if (m_sum73[W-1]) begin
          cls1_d = CLS_RIGHT;
          exp1_d = {1'b0, exp73} + (EXP_W + 1)'(1);
          lz1_d  = '0;
          m1_d   = {m_sum73[W-2:2], m_sum73[1] | m_sum73[0]};
        end else begin
          cls1_d = CLS_LEFT;
          exp1_d = {1'b0, exp73};
          lz1_d  = lz_c;
          m1_d   = m_sum73[W-3:0];
        end
      end
    end
  end

  always_comb begin
    e_pre = {1'b0, exp1_q} - EW'(lz1_q);
`ifdef ROUND_RNE_EN
    norm   = m1_q << lz1_q;
    frac   = norm[W-3:3];
    rnd_up = norm[2] & (norm[1] | norm[0] | frac[0]);
    {wrap, frac_r} = {1'b0, frac} + (MAN_W + 1)'(rnd_up);
    e_fin  = e_pre + EW'(wrap);
`else
    frac_r = MAN_W'((m1_q << lz1_q) >> 3);
    e_fin  = e_pre;
`endif
  end

  always_comb begin
    v2_d       = ld2 ? v1_q : v2_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_mant_d = res_mant_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    uf_d       = uf_q;
    if (ld2 && v1_q) begin
      res_sign_d = sign1_q;
      zero_d     = 1'b0;
      ovf_d      = 1'b0;
      uf_d       = 1'b0;
      if (cls1_q == CLS_ZERO) begin
        res_exp_d  = '0;
        res_mant_d = '0;
        zero_d     = 1'b1;
      end else if (e_fin <= E_ZERO) begin
        res_exp_d  = '0;
        res_mant_d = '0;
        uf_d       = 1'b1;
      end else if (e_fin >= E_MAX) begin
        res_exp_d  = '1;
        res_mant_d = '0;
        ovf_d      = 1'b1;
      end else begin
        res_exp_d  = e_fin[EXP_W-1:0];
        res_mant_d = frac_r;
      end
    end
  end

  always_ff @(posedge clk73 or posedge rst73) begin
    if (rst73) begin
      v1_q       <= 1'b0;
      cls1_q     <= CLS_ZERO;
      sign1_q    <= 1'b0;
      exp1_q     <= '0;
      lz1_q      <= '0;
      m1_q       <= '0;
      v2_q       <= 1'b0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_mant_q <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      cls1_q     <= cls1_d;
      sign1_q    <= sign1_d;
      exp1_q     <= exp1_d;
      lz1_q      <= lz1_d;
      m1_q       <= m1_d;
      v2_q       <= v2_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_mant_q <= res_mant_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      uf_q       <= uf_d;
    end
  end

  assign out_valid73 = v2_q;
  assign res_sign73  = res_sign_q;
  assign res_exp73   = res_exp_q;
  assign res_mant73  = res_mant_q;
  assign zero73      = zero_q;
  assign ovf73       = ovf_q;
  assign uf73        = uf_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe: directed vectors with hand-computed results.
module tb_fp_normalize_pipe;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
    logic       zero;
    logic       ovf;
    logic       uf;
  } res_t;

  logic        clk73 = 1'b0;
  logic        rst73 = 1'b1;
  logic        in_valid73 = 1'b0;
  logic        in_ready73;
  logic        sign73 = 1'b0;
  logic [4:0]  exp73 = '0;
  logic [14:0] m_sum73 = '0;
  logic        out_valid73;
  logic        out_ready73 = 1'b1;
  logic        res_sign73;
  logic [4:0]  res_exp73;
  logic [9:0]  res_mant73;
  logic        zero73, ovf73, uf73;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  bit saw_nrdy = 1'b0;
  res_t exp_q[$];

  fp_normalize_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk73(clk73), .rst73(rst73),
    .in_valid73(in_valid73), .in_ready73(in_ready73),
    .sign73(sign73), .exp73(exp73), .m_sum73(m_sum73),
    .out_valid73(out_valid73), .out_ready73(out_ready73),
    .res_sign73(res_sign73), .res_exp73(res_exp73), .res_mant73(res_mant73),
    .zero73(zero73), .ovf73(ovf73), .uf73(uf73)
  );

  always #5 clk73 = ~clk73;

  function automatic res_t mk(input logic s, input logic [4:0] e, input logic [9:0] m,
                              input logic z, input logic o, input logic u);
    res_t r;
    r.sign = s; r.exp = e; r.mant = m; r.zero = z; r.ovf = o; r.uf = u;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic send(input logic s, input logic [4:0] e, input logic [14:0] m, input res_t r);
    int n = 0;
    in_valid73 = 1'b1;
    sign73 = s; exp73 = e; m_sum73 = m;
    forever begin
      @(negedge clk73);
      if (in_ready73) begin
        exp_q.push_back(r);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck low for exp=%0d m=%h", e, m);
        break;
      end
    end
    @(posedge clk73); #1;
    in_valid73 = 1'b0;
  endtask

  // Compares the head every cycle it is presented, so stall stability is covered too.
  always @(negedge clk73) begin
    if (!rst73 && out_valid73) begin
      res_t got;
      got = {res_sign73, res_exp73, res_mant73, zero73, ovf73, uf73};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h, expected none", got);
      end else begin
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL result: got s=%0b e=%0d m=%h z%0b o%0b u%0b, expected s=%0b e=%0d m=%h z%0b o%0b u%0b",
                   got.sign, got.exp, got.mant, got.zero, got.ovf, got.uf,
                   exp_q[0].sign, exp_q[0].exp, exp_q[0].mant, exp_q[0].zero, exp_q[0].ovf, exp_q[0].uf);
        end
        if (out_ready73) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
    if (!rst73 && !in_ready73) saw_nrdy = 1'b1;
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk73); #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk73);
    #1;
    chk("rst_out_valid", out_valid73, 0);
    chk("rst_in_ready", in_ready73, 1);
    chk("rst_outputs", {res_sign73, res_exp73, res_mant73, zero73, ovf73, uf73}, 0);
    rst73 = 1'b0;
    @(posedge clk73); #1;

    send(0, 15, 15'b10_0000000000_000, mk(0, 16, 10'h000, 0, 0, 0));
    send(1, 15, 15'b00_0001000000_000, mk(1, 11, 10'h000, 0, 0, 0));
    send(0,  3, 15'b00_0001000000_000, mk(0,  0, 10'h000, 0, 0, 1));
    send(0,  4, 15'b00_0001000000_000, mk(0,  0, 10'h000, 0, 0, 1));
    send(0,  5, 15'b00_0001000000_000, mk(0,  1, 10'h000, 0, 0, 0));
`ifdef ROUND_RNE_EN
    send(0, 15, 15'b01_1111111111_100, mk(0, 16, 10'h000, 0, 0, 0));
    send(0, 10, 15'b11_0000000001_110, mk(0, 11, 10'h201, 0, 0, 0));
    send(0, 30, 15'b01_1111111111_110, mk(0, 31, 10'h000, 0, 1, 0));
    send(1, 15, 15'b01_0000000001_100, mk(1, 15, 10'h002, 0, 0, 0));
`else
    send(0, 15, 15'b01_1111111111_100, mk(0, 15, 10'h3FF, 0, 0, 0));
    send(0, 10, 15'b11_0000000001_110, mk(0, 11, 10'h200, 0, 0, 0));
    send(0, 30, 15'b01_1111111111_110, mk(0, 30, 10'h3FF, 0, 0, 0));
    send(1, 15, 15'b01_0000000001_100, mk(1, 15, 10'h001, 0, 0, 0));
`endif
    send(1, 15, 15'b01_0000000000_100, mk(1, 15, 10'h000, 0, 0, 0));
    send(0, 30, 15'b10_0000000000_000, mk(0, 31, 10'h000, 0, 1, 0));
    send(0, 29, 15'b10_0000000000_000, mk(0, 30, 10'h000, 0, 0, 0));
    send(1,  7, 15'b00_0000000000_000, mk(1,  0, 10'h000, 1, 0, 0));
    send(0, 20, 15'b00_0000000001_011, mk(0, 10, 10'h180, 0, 0, 0));
    drain();

    // Six back-to-back beats with a 4-cycle output stall in the middle.
    p0 = popped;
    saw_nrdy = 1'b0;
    fork
      for (int i = 0; i < 6; i++) begin
        logic [9:0] f;
        f = 10'(i * 97 + 5);
        send(i[0], 5'(16 + i), {2'b01, f, 3'b000}, mk(i[0], 5'(16 + i), f, 0, 0, 0));
      end
      begin
        repeat (2) @(posedge clk73);
        #1 out_ready73 = 1'b0;
        repeat (4) @(posedge clk73);
        #1 out_ready73 = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", saw_nrdy, 1);
    chk("bp_beats_out", popped - p0, 6);

    // Reset with two beats in flight.
    send(0, 12, 15'b10_0000000000_000, mk(0, 13, 10'h000, 0, 0, 0));
    send(1, 12, 15'b01_0000000000_000, mk(1, 12, 10'h000, 0, 0, 0));
    #1 rst73 = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid73, 0);
    chk("midrst_in_ready", in_ready73, 1);
    chk("midrst_outputs", {res_sign73, res_exp73, res_mant73, zero73, ovf73, uf73}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk73);
    #1 rst73 = 1'b0;
    repeat (6) @(posedge clk73);
    #1;
    chk("postrst_out_valid", out_valid73, 0);

    send(1, 18, 15'b00_0100000000_000, mk(1, 16, 10'h000, 0, 0, 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
